// File: rtl/demux_8way_collect.sv
// demux_8way_collect: serial-to-parallel collector for the MLP datapath.
// Each accepted N-bit word lands in one of 8 lane registers. Once all 8
// lanes hold fresh data, the packed 8*N bus is offered downstream under a
// valid/ready handshake.
// Optional: define DEMUX_AUTO_SEL_EN to ignore sel and fill the lanes in
// order using an internal wrapping pointer.

module demux_8way_collect_lane #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [N-1:0] data_q, data_d;

  // Load the lane on a write; otherwise hold. A commit or flush does not clear it.
  always_comb begin
    data_d = data_q;
    if (we) data_d = d;
  end

  // Lane storage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;
endmodule

module demux_8way_collect #(
  parameter int N = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     sel,
  input  logic [N-1:0]   in_data,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*N-1:0] out_data,
  output logic [7:0]     lane_mask
);
  typedef enum logic {S_COLLECT = 1'b0, S_FULL = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] lane_idx;
  logic [7:0] lane_oh;
  logic       wr_en, commit;
  logic [7:0] lane_we;

`ifdef DEMUX_AUTO_SEL_EN
  logic [2:0] ptr_q, ptr_d;
  logic       unused_sel;
  assign unused_sel = ^sel;
  assign lane_idx   = ptr_q;
`else
  assign lane_idx   = sel;
`endif

  // Handshake qualifiers; flush overrides both write and commit.
  assign in_ready = (state_q == S_COLLECT);
  assign wr_en    = in_valid && in_ready && !flush;
  assign commit   = (state_q == S_FULL) && out_ready && !flush;
  assign lane_oh  = 8'(1) << lane_idx;
  assign lane_we  = wr_en ? lane_oh : 8'h00;

  // Next-state for the collect/full state, lane mask and pointer.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
`ifdef DEMUX_AUTO_SEL_EN
    ptr_d   = ptr_q;
`endif
    if (flush || commit) begin
      state_d = S_COLLECT;
      mask_d  = 8'h00;
`ifdef DEMUX_AUTO_SEL_EN
      ptr_d   = 3'd0;
`endif
    end else if (wr_en) begin
      mask_d = mask_q | lane_oh;
      if ((mask_q | lane_oh) == 8'hFF) state_d = S_FULL;
`ifdef DEMUX_AUTO_SEL_EN
      ptr_d  = ptr_q + 3'd1;
`endif
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_COLLECT;
      mask_q  <= 8'h00;
`ifdef DEMUX_AUTO_SEL_EN
      ptr_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
`ifdef DEMUX_AUTO_SEL_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // One register per lane; out_data comes straight from these flops.
  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_lane
      demux_8way_collect_lane #(.N(N)) u_lane (
        .clk (clk),
        .rst (rst),
        .we  (lane_we[k]),
        .d   (in_data),
        .q   (out_data[k*N +: N])
      );
    end
  endgenerate

  assign out_valid = (state_q == S_FULL);
  assign lane_mask = mask_q;
endmodule

// File: tb/tb_demux_8way_collect.sv
// Self-checking bench for demux_8way_collect: directed cases plus
// randomized traffic compared against a lane-array reference model.
module tb_demux_8way_collect;
  localparam int N = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, flush, out_valid, out_ready;
  logic [2:0]     sel;
  logic [N-1:0]   in_data;
  logic [8*N-1:0] out_data;
  logic [7:0]     lane_mask;

  demux_8way_collect #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .lane_mask(lane_mask)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [8*N-1:0] got, input logic [8*N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: which lanes were written since the last commit/flush,
  // the lane contents, whether the bus is being offered, and how many words
  // have been accepted in the current collection.
  logic [N-1:0] m_lane [8];
  bit           m_wr   [8];
  bit           m_full;
  int           m_cnt;

  function automatic logic [7:0] m_mask();
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) r[i] = m_wr[i];
    return r;
  endfunction

  function automatic logic [8*N-1:0] m_bus();
    logic [8*N-1:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*N +: N] = m_lane[i];
    return r;
  endfunction

  task automatic m_reset(input bit clear_data);
    for (int i = 0; i < 8; i++) begin
      m_wr[i] = 0;
      if (clear_data) m_lane[i] = '0;
    end
    m_full = 0;
    m_cnt  = 0;
  endtask

  task automatic m_edge(input bit iv, input logic [2:0] s, input logic [N-1:0] d,
                        input bit fl, input bit ordy);
    int  ln;
    bit  all;
    if (fl || (m_full && ordy)) m_reset(0);
    else if (iv && !m_full) begin
`ifdef DEMUX_AUTO_SEL_EN
      ln = m_cnt % 8;
`else
      ln = int'(s);
`endif
      m_lane[ln] = d;
      m_wr[ln]   = 1;
      m_cnt++;
      all = 1;
      for (int i = 0; i < 8; i++) all &= m_wr[i];
      m_full = all;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ov"},   out_valid, m_full);
    chk({tag, "_ir"},   in_ready,  !m_full);
    chk({tag, "_mask"}, lane_mask, m_mask());
    chk({tag, "_data"}, out_data,  m_bus());
  endtask

  // One clock cycle with the given inputs; model advances and outputs are
  // checked 1 time unit after the edge.
  task automatic cyc(input string tag, input bit iv, input logic [2:0] s,
                     input logic [N-1:0] d, input bit fl, input bit ordy);
    in_valid = iv; sel = s; in_data = d; flush = fl; out_ready = ordy;
    @(posedge clk);
    m_edge(iv, s, d, fl, ordy);
    #1;
    in_valid = 0; flush = 0; out_ready = 0;
    check_all(tag);
  endtask

  function automatic logic [N-1:0] lane_of(input int k);
    return out_data[k*N +: N];
  endfunction

  initial begin
    rst = 1; in_valid = 0; sel = 0; in_data = 0; flush = 0; out_ready = 0;
    m_reset(1);
    #12;
    chk("rst_ov",   out_valid, 0);
    chk("rst_mask", lane_mask, 8'h00);
    chk("rst_data", out_data,  '0);
    rst = 0;
    #1;
    chk("rst_ir", in_ready, 1);

`ifndef DEMUX_AUTO_SEL_EN
    // Fill lanes 0..7 in order, hold, then commit.
    for (int k = 0; k < 8; k++) cyc("t1_wr", 1, 3'(k), N'(64'h10 + k), 0, 0);
    chk("t1_ov",   out_valid, 1);
    chk("t1_ir",   in_ready,  0);
    chk("t1_mask", lane_mask, 8'hFF);
    for (int k = 0; k < 8; k++) chk("t1_lane", lane_of(k), N'(64'h10 + k));
    cyc("t1_hold", 1, 3'd2, N'(64'hDEAD), 0, 0);
    chk("t1_hold_l2", lane_of(2), N'(64'h12));
    cyc("t2_commit", 0, 3'd0, '0, 0, 1);
    chk("t2_ov",   out_valid, 0);
    chk("t2_mask", lane_mask, 8'h00);
    chk("t2_ir",   in_ready,  1);
    for (int k = 0; k < 8; k++) chk("t2_lane", lane_of(k), N'(64'h10 + k));

    // Overwrite lane 3 before completing the set.
    cyc("t3_a", 1, 3'd3, N'(64'hAA), 0, 0);
    cyc("t3_b", 1, 3'd3, N'(64'hBB), 0, 0);
    chk("t3_mask", lane_mask, 8'h08);
    for (int k = 0; k < 8; k++) if (k != 3) begin
      chk("t3_ov_early", out_valid, 0);
      cyc("t3_w", 1, 3'(k), N'(64'h30 + k), 0, 0);
    end
    chk("t3_ov",    out_valid, 1);
    chk("t3_lane3", lane_of(3), N'(64'hBB));
    cyc("t3_commit", 0, 3'd0, '0, 0, 1);

    // Flush wins over a simultaneous write.
    for (int k = 0; k < 5; k++) cyc("t4_w", 1, 3'(k), N'(64'h40 + k), 0, 0);
    cyc("t4_flush", 1, 3'd5, N'(64'h55), 1, 0);
    chk("t4_mask",  lane_mask, 8'h00);
    chk("t4_lane5", lane_of(5), N'(64'h35));
    for (int k = 0; k < 7; k++) cyc("t4_refill", 1, 3'(k), N'(64'h50 + k), 0, 0);
    chk("t4_ov_7", out_valid, 0);
    cyc("t4_last", 1, 3'd7, N'(64'h57), 0, 0);
    chk("t4_ov_8", out_valid, 1);
`else
    // Auto-select: sel is ignored, lanes fill in arrival order.
    for (int k = 0; k < 8; k++) begin
      chk("t6_ov_early", out_valid, 0);
      cyc("t6_w", 1, 3'd7, N'(k), 0, 0);
    end
    chk("t6_ov", out_valid, 1);
    for (int k = 0; k < 8; k++) chk("t6_lane", lane_of(k), N'(k));
    cyc("t6_commit", 0, 3'd7, '0, 0, 1);
    cyc("t6_next", 1, 3'd7, N'(64'h99), 0, 0);
    chk("t6_lane0", lane_of(0), N'(64'h99));
    chk("t6_mask",  lane_mask, 8'h01);
    cyc("t6_flush", 0, 3'd7, '0, 1, 0);
    for (int k = 0; k < 8; k++) cyc("t6_fill", 1, 3'd7, N'(64'h60 + k), 0, 0);
`endif

    // Commit and flush together while full: flush path.
    if (!m_full) for (int k = 0; k < 8; k++) cyc("t5_fill", 1, 3'(k), N'(64'h70 + k), 0, 0);
    chk("t5_full", out_valid, 1);
    cyc("t5_fl_cm", 0, 3'd0, '0, 1, 1);
    chk("t5_ov",   out_valid, 0);
    chk("t5_mask", lane_mask, 8'h00);

    // Asynchronous reset mid-collection.
    for (int k = 0; k < 3; k++) cyc("t5_w", 1, 3'(k), N'(64'h80 + k), 0, 0);
    #2 rst = 1;
    #1;
    m_reset(1);
    chk("t5_rst_ov",   out_valid, 0);
    chk("t5_rst_mask", lane_mask, 8'h00);
    chk("t5_rst_data", out_data,  '0);
    @(negedge clk) rst = 0;
    #1;
    chk("t5_rst_ir", in_ready, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc("rnd",
          ($urandom_range(0, 99) < 75),
          3'($urandom_range(0, 7)),
          {$urandom, $urandom},
          ($urandom_range(0, 99) < 4),
          ($urandom_range(0, 99) < 35));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_8way_collect.md
Name: demux_8way_collect

Overview:
- Inverse of the 8-input operand selector used in the MLP datapath.
- Accepts one N-bit word per handshake and steers it into one of 8 lane registers.
- Once all 8 lanes hold fresh data, presents them as one packed 8*N bus to the downstream layer with a valid/ready handshake.
- Sits between the serial weight/activation fetch path and the wide parallel multiply stage.

Parameters:
- N, 64, width of each lane word in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word; equals !out_valid.
- sel  input  3  destination lane index 0..7; ignored when AUTO_SEL_EN is defined.
- in_data  input  N  word to store.
- flush  input  1  synchronous abort of the current collection.
- out_valid  output  1  all 8 lanes filled; out_data is stable.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  8*N  packed lanes; lane k occupies bits [k*N +: N].
- lane_mask  output  8  bit k set means lane k has been written since the last commit or flush.

Behaviour:
- Reset (async, rst=1):
  - All lane registers = 0; out_data = 0.
  - lane_mask = 8'h00; out_valid = 0.
  - Auto-select pointer = 0.
  - in_ready = 1 once reset releases.
- Write: on a clk edge with in_valid && in_ready && !flush:
  - lane[sel] <= in_data; lane_mask[sel] <= 1.
  - Rewriting an already-set lane overwrites its data; lane_mask is unchanged; no error is raised.
- Fill detect: if (lane_mask | onehot(sel)) == 8'hFF at a write edge, out_valid <= 1 on that same edge.
  - Latency: out_valid is visible the cycle after the 8th distinct lane write.
  - Minimum of 8 accepted words per output.
- Hold state (out_valid = 1):
  - in_ready = 0, so no writes occur.
  - out_data and lane_mask remain constant until the output is consumed or flushed.
- Commit: on an edge with out_valid && out_ready:
  - out_valid <= 0; lane_mask <= 0; auto-select pointer <= 0.
  - Lane data is retained, not cleared.
  - in_ready rises in the next cycle; there is no same-cycle accept, so no overlap between the output hand-off and a new write.
- Flush: on an edge with flush = 1:
  - lane_mask <= 0; out_valid <= 0; pointer <= 0; lane data retained.
  - Flush has priority over both write and commit; a pending output is dropped without a handshake.
- in_valid while in_ready = 0: ignored; the upstream source must hold the word.
- out_data is driven directly from the lane registers; no combinational path from in_data to out_data.
- State summary:
  - COLLECT (out_valid = 0) moves to FULL on the 8th distinct lane write.
  - FULL moves to COLLECT on commit or flush.
  - COLLECT stays in COLLECT on flush.
- Reset asserted mid-collection or mid-FULL returns every register to its reset value immediately, without waiting for a clock edge.

Optional Feature:
- Macro: DEMUX_AUTO_SEL_EN.
- Defined:
  - The sel port is ignored.
  - An internal 3-bit pointer chooses the lane; it increments on each accepted write, wrapping 7 -> 0.
  - The pointer resets to 0 on rst, commit and flush.
  - Fill therefore occurs exactly on the 8th accepted word.
- Not defined:
  - The lane comes from the sel port; no pointer logic is synthesized.

Test Plan:
1. After reset, write lanes 0..7 with data 0x10+k in consecutive cycles; hold out_ready=0. Expect out_valid=1 one cycle after the last write, in_ready=0, lane_mask=8'hFF, out_data lane k = 0x10+k.
2. From the held state of test 1, pulse out_ready=1 for one cycle. Expect out_valid=0 and lane_mask=8'h00 next cycle, in_ready=1, out_data still 0x10+k.
3. Write lane 3 = 0xAA, then lane 3 = 0xBB, then the remaining 7 lanes. Expect lane_mask=8'h08 after both lane-3 writes, out_valid only after all 8 distinct lanes, lane 3 = 0xBB.
4. Write lanes 0..4, assert flush together with a lane-5 write. Expect lane_mask=8'h00, lane 5 not written, out_valid=0; then 8 more writes are required before out_valid rises.
5. Assert out_valid, then assert out_ready and flush in the same cycle. Expect out_valid=0 and the flush path taken. Separately, assert rst mid-collection: all outputs 0 immediately, in_ready=1 after release.
6. With DEMUX_AUTO_SEL_EN defined, drive sel=7 constantly and write 8 words 0x0..0x7. Expect lane k = k, out_valid after the 8th word; after commit, the next word lands in lane 0.
